// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional build macro: IFU_FAULT_DET_EN adds the HALT state used by
// unmapped-fetch fault detection.
package fetch_pkg;

  localparam logic [31:0] WORD_BYTES   = 32'd4;
  localparam logic [31:0] ROM_UNMAPPED = 32'hFFFF_FFFF;
  localparam logic [31:0] PC8_OFFSET   = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

`ifdef IFU_FAULT_DET_EN
  typedef enum logic [1:0] {RUN, STALL, HALT} ifu_state_t;
`else
  typedef enum logic [1:0] {RUN, STALL} ifu_state_t;
`endif

  // Clear the byte-offset bits of an address.
  function automatic logic [31:0] word_align(input logic [31:0] adr);
    return {adr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with push, pop and flush.
// Flush beats push; a pop and a push may coincide on a full queue.
// When empty, the head port keeps showing the last entry that was popped
// (zero after reset) so decode sees stable values.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wr_entry,
  input  logic         pop,
  output fetch_entry_t head_entry,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  hold_q, hold_d;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok) & ~flush;

  assign head_entry = empty ? hold_q : mem_q[rd_ptr_q];

  // Pointer/count next state; flush empties the queue regardless of push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = hold_q;
    if (pop_ok) begin
      hold_d = mem_q[rd_ptr_q];
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Control registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Entry storage; contents are only reachable through the pointers.
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses a combinational ROM,
// queues {pc, word} pairs and hands them to decode over valid/ready.
// Optional build macro: IFU_FAULT_DET_EN enables unmapped-fetch detection
// (fetch_fault port and HALT state).
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] rom_adr,
  input  logic [31:0] rom_dout,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc8
`ifdef IFU_FAULT_DET_EN
  ,
  output logic        fetch_fault
`endif
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pc8_hold_q, pc8_hold_d;
  ifu_state_t   state_q, state_d;
  logic         q_full, q_empty;
  logic         pop, push, unmapped;
  fetch_entry_t head;
  fetch_entry_t new_entry;

`ifdef IFU_FAULT_DET_EN
  logic fault_q, fault_d;
  assign unmapped    = (state_q == RUN) && (rom_dout == ROM_UNMAPPED);
  assign fetch_fault = fault_q;
`else
  assign unmapped = 1'b0;
`endif

  assign rom_adr   = pc_q;
  assign out_valid = ~q_empty;
  assign pop       = out_valid & out_ready;
  assign push      = (state_q == RUN) & ~redirect_valid & (~q_full | pop) & ~unmapped;
  assign new_entry = '{pc: pc_q, instr: rom_dout};

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .wr_entry   (new_entry),
    .pop        (pop),
    .head_entry (head),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  // The pc+8 view must read zero after reset, so it is held alongside the head.
  assign out_pc8   = q_empty ? pc8_hold_q : (head.pc + PC8_OFFSET);

  // PC and fetch-state next-state logic; redirect overrides everything.
  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    pc8_hold_d = pc8_hold_q;
`ifdef IFU_FAULT_DET_EN
    fault_d    = fault_q;
`endif
    if (pop) begin
      pc8_hold_d = head.pc + PC8_OFFSET;
    end
    if (redirect_valid) begin
      pc_d    = word_align(redirect_pc);
      state_d = RUN;
`ifdef IFU_FAULT_DET_EN
      fault_d = 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (unmapped) begin
`ifdef IFU_FAULT_DET_EN
            state_d = HALT;
            fault_d = 1'b1;
`endif
          end else if (push) begin
            pc_d = pc_q + WORD_BYTES;
          end else begin
            // No push in RUN without a fault means full with no pop.
            state_d = STALL;
          end
        end
        STALL: begin
          if (pop) state_d = RUN;
        end
        default: begin
          // HALT: wait for redirect or reset.
          state_d = state_q;
        end
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= word_align(RESET_PC);
      state_q    <= RUN;
      pc8_hold_q <= '0;
`ifdef IFU_FAULT_DET_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      pc8_hold_q <= pc8_hold_d;
`ifdef IFU_FAULT_DET_EN
      fault_q    <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (QDEPTH=2) paired with a small
// program ROM. Directed scenarios first, then randomized traffic, all
// compared against a queue-based reference model every cycle.
// Optional build macro: IFU_FAULT_DET_EN (fault detection enabled in the DUT).
module tb_instr_fetch_unit;

`ifdef IFU_FAULT_DET_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [31:0] rom_adr;
  logic [31:0] rom_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc8;
`ifdef IFU_FAULT_DET_EN
  logic        fetch_fault;
`endif

  int vectors;
  int miscompares;

  // Program ROM contents.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hE590_1000;
      32'h0000_0004: return 32'hE590_2001;
      32'h0000_002C: return 32'hE590_F000;
      32'h0000_0038: return 32'hFFFF_FFFF;
      default:       return {16'hA5A5, a[17:2]};
    endcase
  endfunction

  assign rom_dout = rom_word(rom_adr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rom_adr        (rom_adr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc8        (out_pc8)
`ifdef IFU_FAULT_DET_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a list of queued {pc, instr}, the fetch PC, and flags.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic [63:0] m_last;
  logic [31:0] m_last_pc8;
  bit          m_stalled;
  bit          m_halted;
  bit          m_fault;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst_n, input bit rdv, input logic [31:0] rpc, input bit rdy);
    int          n;
    bit          popped;
    logic [31:0] w;
    if (!rst_n) begin
      mq.delete();
      m_pc       = 32'h0;
      m_last     = '0;
      m_last_pc8 = '0;
      m_stalled  = 0;
      m_halted   = 0;
      m_fault    = 0;
    end else begin
      n      = mq.size();
      popped = (n > 0) && rdy;
      w      = rom_word(m_pc);
      if (popped) begin
        m_last     = mq.pop_front();
        m_last_pc8 = m_last[63:32] + 32'd8;
      end
      if (rdv) begin
        mq.delete();
        m_pc      = {rpc[31:2], 2'b00};
        m_stalled = 0;
        m_halted  = 0;
        m_fault   = 0;
      end else if (m_halted) begin
        m_halted = 1;
      end else if (m_stalled) begin
        if (popped) m_stalled = 0;
      end else if (FAULT_EN && w == 32'hFFFF_FFFF) begin
        m_halted = 1;
        m_fault  = 1;
      end else if (n < 2 || popped) begin
        mq.push_back({m_pc, w});
        m_pc = m_pc + 32'd4;
      end else begin
        m_stalled = 1;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] head;
    logic [31:0] pc8;
    bit          v;
    v    = (mq.size() > 0);
    head = v ? mq[0] : m_last;
    pc8  = v ? head[63:32] + 32'd8 : m_last_pc8;
    check("out_valid", 32'(out_valid), 32'(v));
    check("rom_adr", rom_adr, m_pc);
    check("out_instr", out_instr, head[31:0]);
    check("out_pc", out_pc, head[63:32]);
    check("out_pc8", out_pc8, pc8);
`ifdef IFU_FAULT_DET_EN
    check("fetch_fault", 32'(fetch_fault), 32'(m_fault));
`endif
  endtask

  // One clock: drive inputs mid-cycle, let the edge happen, then compare.
  task automatic step(input bit rst_n, input bit rdv, input logic [31:0] rpc, input bit rdy);
    @(negedge clk);
    reset_n        = rst_n;
    redirect_valid = rdv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_update(rst_n, rdv, rpc, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] tgt;
    int          sel;
    vectors        = 0;
    miscompares    = 0;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;

    // 1: straight-line fetch from reset.
    step(0, 0, 0, 1);
    check("t1_rst_valid", 32'(out_valid), 32'h0);
    check("t1_rst_adr", rom_adr, 32'h0);
    check("t1_rst_pc8", out_pc8, 32'h0);
    step(1, 0, 0, 1);
    check("t1_adr4", rom_adr, 32'h4);
    check("t1_head0", out_instr, 32'hE590_1000);
    check("t1_pc0", out_pc, 32'h0);
    step(1, 0, 0, 1);
    check("t1_adr8", rom_adr, 32'h8);
    check("t1_head1", out_instr, 32'hE590_2001);
    check("t1_pc4", out_pc, 32'h4);
    check("t1_pc8", out_pc8, 32'hC);
    $display("test 1 straight fetch done");

    // 2: back-pressure from reset, then release.
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("t2_adr_held", rom_adr, 32'h8);
    check("t2_head0", out_pc, 32'h0);
    step(1, 0, 0, 1);
    check("t2_head4", out_pc, 32'h4);
    check("t2_valid4", 32'(out_valid), 32'h1);
    step(1, 0, 0, 1);
    check("t2_head8", out_pc, 32'h8);
    check("t2_instr8", out_instr, rom_word(32'h8));
    $display("test 2 stall and release done");

    // 3: full queue with simultaneous push and pop each cycle.
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0, 1);
      check("t3_pc", out_pc, 32'(4 * k));
      check("t3_adr", rom_adr, 32'(4 * k + 8));
    end
    $display("test 3 full streaming done");

    // 4: redirect while full.
    step(1, 1, 32'h2D, 1);
    check("t4_valid", 32'(out_valid), 32'h0);
    check("t4_adr", rom_adr, 32'h2C);
    step(1, 0, 0, 1);
    check("t4_instr", out_instr, 32'hE590_F000);
    check("t4_pc", out_pc, 32'h2C);
    $display("test 4 redirect done");

    // 5: fetch from the unmapped word.
    step(1, 1, 32'h38, 1);
    step(1, 0, 0, 1);
`ifdef IFU_FAULT_DET_EN
    check("t5_fault", 32'(fetch_fault), 32'h1);
    check("t5_valid", 32'(out_valid), 32'h0);
    check("t5_adr", rom_adr, 32'h38);
    step(1, 0, 0, 1);
    check("t5_adr_hold", rom_adr, 32'h38);
    step(1, 1, 32'h0, 1);
    check("t5_fault_clr", 32'(fetch_fault), 32'h0);
    step(1, 0, 0, 1);
    check("t5_refetch", out_instr, 32'hE590_1000);
    check("t5_refetch_pc", out_pc, 32'h0);
`else
    check("t5_queued", out_instr, 32'hFFFF_FFFF);
    check("t5_queued_pc", out_pc, 32'h38);
`endif
    $display("test 5 unmapped fetch done");

    // 6: reset with a full queue.
    step(1, 1, 32'h100, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    check("t6_valid", 32'(out_valid), 32'h0);
    check("t6_adr", rom_adr, 32'h0);
    step(1, 0, 0, 0);
    check("t6_head_pc", out_pc, 32'h0);
    check("t6_head_instr", out_instr, 32'hE590_1000);
    $display("test 6 mid-stream reset done");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       tgt = 32'h0;
        1:       tgt = 32'h2D;
        2:       tgt = 32'h38;
        3:       tgt = 32'hFFFF_FFF5;
        4:       tgt = $urandom_range(0, 255);
        default: tgt = $urandom;
      endcase
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 10), tgt,
           ($urandom_range(0, 99) < 65));
    end
    $display("random phase done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
